// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types for the SRAM RW-port arbiter.
// Arbiter states, default macro geometry and the request bundle.
package sram_arb_pkg;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 32;
  localparam int WMASK_W = DATA_W / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [WMASK_W-1:0] wmask;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } req_t;

  // ptr=0 prefers requester 0 on a tie
  function automatic logic [1:0] rr_pick(
    input logic [1:0] valid,
    input logic       ptr
  );
    logic [1:0] g;
    g = valid;
    if (&valid) g = ptr ? 2'b10 : 2'b01;
    return g;
  endfunction

endpackage

// File: rtl/sram_rw_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin arbiter with one-hot grant.
// The pointer flips to the other side after every grant.
module rr_arbiter_2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr_q;

  assign grant = en ? rr_pick(valid, ptr_q) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (|grant) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: shares SRAM port 0 between fetch and load/store.
// Define SRAM_ZERO_INIT_EN to zero-fill the array after reset.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int NUM_WMASKS = WMASK_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_we_i,
  input  logic [NUM_WMASKS-1:0] req0_wmask_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  output logic                  rsp0_valid_o,
  output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_we_i,
  input  logic [NUM_WMASKS-1:0] req1_wmask_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  output logic                  rsp1_valid_o,
  output logic [DATA_WIDTH-1:0] rsp1_rdata_o,
  output logic                  init_done_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } port_req_t;

  port_req_t             req0;
  port_req_t             req1;
  port_req_t             sel;
  arb_state_e            state_q;
  logic                  sweep;
  logic                  run;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [1:0]            grant;
  logic [1:0]            rsp_q;

  assign req0 = {req0_we_i, req0_wmask_i, req0_addr_i, req0_wdata_i};
  assign req1 = {req1_we_i, req1_wmask_i, req1_addr_i, req1_wdata_i};

`ifdef SRAM_ZERO_INIT_EN
  arb_state_e            state_d;
  logic [ADDR_WIDTH-1:0] init_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: if (&init_cnt) state_d = RUN;
      RUN:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_cnt <= '0;
    end else if (state_q == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  assign init_addr = init_cnt;
`else
  assign state_q   = RUN;
  assign init_addr = '0;
`endif

  // Gating with rst_ni keeps the macro idle while reset is held
  assign sweep       = (state_q == INIT) && rst_ni;
  assign run         = (state_q == RUN) && rst_ni;
  assign init_done_o = (state_q == RUN);

  rr_arbiter_2 u_rr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (run),
    .valid ({req1_valid_i, req0_valid_i}),
    .grant (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_comb begin
    sel = grant[1] ? req1 : req0;
  end

  always_comb begin
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;
    unique case (1'b1)
      sweep: begin
        sram_csb0_o   = 1'b0;
        sram_web0_o   = 1'b0;
        sram_wmask0_o = '1;
        sram_addr0_o  = init_addr;
      end
      (|grant): begin
        sram_csb0_o   = 1'b0;
        sram_web0_o   = ~sel.we;
        sram_wmask0_o = sel.we ? sel.wmask : '0;
        sram_addr0_o  = sel.addr;
        sram_din0_o   = sel.wdata;
      end
      default: ;
    endcase
  end

  // Read tag: which side gets the macro output next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= 2'b00;
    end else begin
      rsp_q <= {grant[1] & ~req1_we_i, grant[0] & ~req0_we_i};
    end
  end

  assign rsp0_valid_o = rsp_q[0];
  assign rsp1_valid_o = rsp_q[1];
  assign rsp0_rdata_o = sram_dout0_i;
  assign rsp1_rdata_o = sram_dout0_i;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// tb_sram_rw_arbiter: scoreboard bench for sram_rw_arbiter.
// Behavioural macro model plus shadow memory for expected data.
module tb_sram_rw_arbiter;
  import sram_arb_pkg::*;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk;
  logic        rst_ni;
  logic        req0_valid, req0_ready, req0_we;
  logic [3:0]  req0_wmask;
  logic [10:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [3:0]  req1_wmask;
  logic [10:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        init_done;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [10:0] sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  logic [31:0] mem     [0:2047];
  logic [31:0] exp_mem [0:2047];
  exp_t        q0[$];
  exp_t        q1[$];
  logic        exp_ptr;
  int          cyc;
  int          tests_run;
  int          failed;

  sram_rw_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready),
    .req0_we_i     (req0_we),
    .req0_wmask_i  (req0_wmask),
    .req0_addr_i   (req0_addr),
    .req0_wdata_i  (req0_wdata),
    .rsp0_valid_o  (rsp0_valid),
    .rsp0_rdata_o  (rsp0_rdata),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready),
    .req1_we_i     (req1_we),
    .req1_wmask_i  (req1_wmask),
    .req1_addr_i   (req1_addr),
    .req1_wdata_i  (req1_wdata),
    .rsp1_valid_o  (rsp1_valid),
    .rsp1_rdata_o  (rsp1_rdata),
    .init_done_o   (init_done),
    .sram_csb0_o   (sram_csb0),
    .sram_web0_o   (sram_web0),
    .sram_wmask0_o (sram_wmask0),
    .sram_addr0_o  (sram_addr0),
    .sram_din0_o   (sram_din0),
    .sram_dout0_i  (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Macro model: one-cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic req_t mk(input logic we, input logic [3:0] m,
                              input logic [10:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.wmask = m; r.addr = a; r.wdata = d;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rsp0_valid) begin
      tests_run++;
      if (q0.size() == 0) begin
        failed++;
        $display("FAIL rsp0_unexpected: valid=1 required 0 at cycle %0d", cyc);
      end else begin
        e = q0.pop_front();
        if (rsp0_rdata !== e.d || cyc != e.c + 1) begin
          failed++;
          $display("FAIL rsp0_data: got %h at cyc %0d, required %h at cyc %0d",
                   rsp0_rdata, cyc, e.d, e.c + 1);
        end
      end
    end else if (q0.size() != 0 && cyc > q0[0].c) begin
      tests_run++; failed++;
      $display("FAIL rsp0_missing: valid=0 required 1 at cycle %0d", cyc);
      void'(q0.pop_front());
    end
    if (rsp1_valid) begin
      tests_run++;
      if (q1.size() == 0) begin
        failed++;
        $display("FAIL rsp1_unexpected: valid=1 required 0 at cycle %0d", cyc);
      end else begin
        e = q1.pop_front();
        if (rsp1_rdata !== e.d || cyc != e.c + 1) begin
          failed++;
          $display("FAIL rsp1_data: got %h at cyc %0d, required %h at cyc %0d",
                   rsp1_rdata, cyc, e.d, e.c + 1);
        end
      end
    end else if (q1.size() != 0 && cyc > q1[0].c) begin
      tests_run++; failed++;
      $display("FAIL rsp1_missing: valid=0 required 1 at cycle %0d", cyc);
      void'(q1.pop_front());
    end
  end

  task automatic issue(input logic v0, input req_t r0,
                       input logic v1, input req_t r1,
                       output logic [1:0] g);
    req_t r;
    exp_t e;
    @(posedge clk); #1;
    req0_valid = v0; req0_we = r0.we; req0_wmask = r0.wmask;
    req0_addr = r0.addr; req0_wdata = r0.wdata;
    req1_valid = v1; req1_we = r1.we; req1_wmask = r1.wmask;
    req1_addr = r1.addr; req1_wdata = r1.wdata;
    if (v0 && v1) g = exp_ptr ? 2'b10 : 2'b01;
    else g = {v1, v0};
    #2;
    tests_run++;
    if ({req1_ready, req0_ready} !== g) begin
      failed++;
      $display("FAIL grant: ready=%b required %b", {req1_ready, req0_ready}, g);
    end
    if (g != 2'b00) begin
      r = g[0] ? r0 : r1;
      exp_ptr = g[0];
      tests_run++;
      if (sram_csb0 !== 1'b0 || sram_web0 !== ~r.we || sram_addr0 !== r.addr) begin
        failed++;
        $display("FAIL sram_cmd: csb=%b web=%b addr=%h required 0 %b %h",
                 sram_csb0, sram_web0, sram_addr0, ~r.we, r.addr);
      end
      if (r.we) begin
        tests_run++;
        if (sram_wmask0 !== r.wmask || sram_din0 !== r.wdata) begin
          failed++;
          $display("FAIL sram_wr: wmask=%h din=%h required %h %h",
                   sram_wmask0, sram_din0, r.wmask, r.wdata);
        end
        exp_mem[r.addr] = merge(exp_mem[r.addr], r.wdata, r.wmask);
      end else begin
        e.d = exp_mem[r.addr];
        e.c = cyc;
        if (g[0]) q0.push_back(e);
        else q1.push_back(e);
      end
    end else begin
      tests_run++;
      if (sram_csb0 !== 1'b1) begin
        failed++;
        $display("FAIL sram_idle: csb=%b required 1", sram_csb0);
      end
    end
  endtask

  task automatic idle();
    logic [1:0] g;
    issue(1'b0, mk(0, 0, 0, 0), 1'b0, mk(0, 0, 0, 0), g);
  endtask

`ifdef SRAM_ZERO_INIT_EN
  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (n != 2048) begin
      failed++;
      $display("FAIL init_cycles: %0d required 2048", n);
    end
    for (int i = 0; i < 2048; i++) exp_mem[i] = 32'h0;
  endtask
`endif

  task automatic test_reset();
    logic [1:0] g;
    rst_ni = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_wmask = 4'h0;
    req0_addr = 11'h7FF; req0_wdata = 32'h0;
    req1_valid = 1'b1; req1_we = 1'b1; req1_wmask = 4'hF;
    req1_addr = 11'h001; req1_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_hs: ready=%b rsp=%b required 00 00",
               {req1_ready, req0_ready}, {rsp1_valid, rsp0_valid});
    end
    tests_run++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_wmask0 !== 4'h0 ||
        sram_addr0 !== 11'h0 || sram_din0 !== 32'h0) begin
      failed++;
      $display("FAIL reset_sram: csb=%b web=%b m=%h a=%h d=%h required 1 1 0 0 0",
               sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
`ifdef SRAM_ZERO_INIT_EN
    tests_run++;
    if (init_done !== 1'b0 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 ||
        sram_addr0 !== 11'h0 || sram_wmask0 !== 4'hF || sram_din0 !== 32'h0) begin
      failed++;
      $display("FAIL sweep_start: done=%b csb=%b web=%b a=%h m=%h d=%h required 0 0 0 0 f 0",
               init_done, sram_csb0, sram_web0, sram_addr0, sram_wmask0, sram_din0);
    end
    wait_init();
`else
    tests_run++;
    if (init_done !== 1'b1) begin
      failed++;
      $display("FAIL init_done: %b required 1", init_done);
    end
`endif
    issue(1'b1, mk(0, 0, 11'h7FF, 0), 1'b0, mk(0, 0, 0, 0), g);
    idle();
  endtask

  task automatic test_write_read();
    logic [1:0] g;
    issue(1'b1, mk(1, 4'hF, 11'h010, 32'hDEADBEEF), 1'b0, mk(0, 0, 0, 0), g);
    issue(1'b1, mk(0, 4'h0, 11'h010, 32'h0), 1'b0, mk(0, 0, 0, 0), g);
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    issue(1'b1, mk(1, 4'hF, 11'h001, 32'hA0A0_0001), 1'b0, mk(0, 0, 0, 0), g);
    issue(1'b0, mk(0, 0, 0, 0), 1'b1, mk(1, 4'hF, 11'h002, 32'hB0B0_0002), g);
    for (int i = 0; i < 4; i++)
      issue(1'b1, mk(0, 0, 11'h001, 0), 1'b1, mk(0, 0, 11'h002, 0), g);
    idle();
  endtask

  task automatic test_byte_write();
    logic [1:0] g;
    issue(1'b0, mk(0, 0, 0, 0), 1'b1, mk(1, 4'hF, 11'h020, 32'h11223344), g);
    issue(1'b0, mk(0, 0, 0, 0), 1'b1, mk(1, 4'b0001, 11'h020, 32'h000000AA), g);
    issue(1'b0, mk(0, 0, 0, 0), 1'b1, mk(0, 0, 11'h020, 0), g);
    idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    logic       p0v, p1v;
    req_t       p0, p1;
    p0v = 1'b0; p1v = 1'b0;
    p0 = mk(0, 0, 0, 0); p1 = p0;
    for (int i = 0; i < 40; i++) begin
      if (!p0v && $urandom_range(0, 3) != 0) begin
        p0v = 1'b1;
        p0 = mk($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)),
                11'(11'h030 + $urandom_range(0, 3)), $urandom);
      end
      if (!p1v && $urandom_range(0, 3) != 0) begin
        p1v = 1'b1;
        p1 = mk($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)),
                11'(11'h030 + $urandom_range(0, 3)), $urandom);
      end
      issue(p0v, p0, p1v, p1, g);
      if (g[0]) p0v = 1'b0;
      if (g[1]) p1v = 1'b0;
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    logic [1:0] g;
    issue(1'b1, mk(0, 0, 11'h010, 0), 1'b0, mk(0, 0, 0, 0), g);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    tests_run++;
    if (rsp0_valid !== 1'b1) begin
      failed++;
      $display("FAIL in_flight: rsp0_valid=%b required 1", rsp0_valid);
    end
    rst_ni = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests_run++;
    if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== 4'b0000 ||
        sram_csb0 !== 1'b1) begin
      failed++;
      $display("FAIL mid_reset: rsp=%b ready=%b csb=%b required 00 00 1",
               {rsp1_valid, rsp0_valid}, {req1_ready, req0_ready}, sram_csb0);
    end
    q0.delete(); q1.delete();
    exp_ptr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
`ifdef SRAM_ZERO_INIT_EN
    tests_run++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 11'h0) begin
      failed++;
      $display("FAIL sweep_restart: csb=%b web=%b a=%h required 0 0 000",
               sram_csb0, sram_web0, sram_addr0);
    end
    wait_init();
`endif
    issue(1'b1, mk(0, 0, 11'h001, 0), 1'b1, mk(0, 0, 11'h002, 0), g);
    issue(1'b0, mk(0, 0, 0, 0), 1'b1, mk(0, 0, 11'h002, 0), g);
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; failed = 0; cyc = 0; exp_ptr = 1'b0;
    sram_dout0 = 32'h0;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 32'hC0DE_0000 | 32'(i);
      exp_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_byte_write();
    test_back_to_back();
    test_reset_midstream();
    idle();
    tests_run++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failed++;
      $display("FAIL drain: pending %0d/%0d required 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
